instruction_fetch_unit: RTL and testbench

Front end of the single-issue MIPS core. Fetches 32-bit instruction words from instruction memory over a valid/ready request and response interface. Delivers each word, with its PC and the opcode/func fields, to the decode stage through a valid/ready handshake. Takes redirects from branch/jump resolution and the halt flag from decode.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ifu_redirect_tracker.sv | 56 +++++
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end and decoder.
// Instruction field positions, opcode constants and fetch FSM states.
package cpu_pkg;

    localparam int INST_WIDTH   = 32;
    localparam int PC_INCREMENT = 4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    // SYSCALL is an R-type encoding selected by the func field
    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] FUNC_SYSCALL = 6'h0C;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DELIVER,
        HALT
    } ifu_state_t;

endpackage

// File: rtl/ifu_redirect_tracker.sv
// Redirect bookkeeping for the fetch unit: squash flag, stored target
// and the priority between redirects and the sequential PC.
module ifu_redirect_tracker
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  ifu_state_t            state,
    input  logic                  req_fire,
    input  logic                  rsp_valid,
    input  logic                  halt_take,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] resume_pc,
    output logic                  fetch_redirect,
    output logic                  deliver_redirect,
    output logic                  drop_rsp
);

    logic                  squash_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic                  in_fetch;
    logic                  in_wait;
    logic                  in_deliver;
    logic                  arm;

    assign in_fetch   = (state == FETCH);
    assign in_wait    = (state == WAIT);
    assign in_deliver = (state == DELIVER);

    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

    // A redirect seen while a request is in flight poisons its response
    assign arm = redirect_valid & ((in_fetch & req_fire) | in_wait);

    assign fetch_redirect   = redirect_valid & in_fetch & ~req_fire;
    assign deliver_redirect = redirect_valid & in_deliver & ~halt_take;
    assign drop_rsp  = in_wait & rsp_valid & (squash_q | redirect_valid);
    assign resume_pc = redirect_valid ? redirect_target : target_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            squash_q <= 1'b0;
            target_q <= '0;
        end else if (in_wait && rsp_valid) begin
            squash_q <= 1'b0;
        end else if (arm) begin
            squash_q <= 1'b1;
            target_q <= redirect_target;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: imem request/response to decode handshake.
// Define IFU_PERF_CNT_EN to add fetch_count and squash_count outputs.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_b,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [5:0]            opcode,
    output logic [5:0]            func,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halted,
    output logic                  halted_out
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           squash_count
`endif
);

    ifu_state_t            state_q;
    ifu_state_t            state_d;
    logic                  armed_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_out_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  req_fire;
    logic                  hs;
    logic                  halt_take;
    logic                  rsp_take;
    logic                  fetch_redirect;
    logic                  deliver_redirect;
    logic                  drop_rsp;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ADDR_WIDTH-1:0] resume_pc;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign hs        = inst_valid & inst_ready;
    assign halt_take = hs & halted;
    assign rsp_take  = (state_q == WAIT) & imem_rsp_valid & ~drop_rsp;

    ifu_redirect_tracker #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_tracker (
        .clk              (clk),
        .rst_b            (rst_b),
        .state            (state_q),
        .req_fire         (req_fire),
        .rsp_valid        (imem_rsp_valid),
        .halt_take        (halt_take),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_target  (redirect_target),
        .resume_pc        (resume_pc),
        .fetch_redirect   (fetch_redirect),
        .deliver_redirect (deliver_redirect),
        .drop_rsp         (drop_rsp)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   if (req_fire) state_d = WAIT;
            WAIT: begin
                if (imem_rsp_valid)
                    state_d = drop_rsp ? FETCH : DELIVER;
            end
            DELIVER: begin
                if (halt_take)
                    state_d = HALT;
                else if (hs || deliver_redirect)
                    state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // armed_q keeps the request low during reset and its first cycle out
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        halted_out     = 1'b0;
        unique case (state_q)
            FETCH:   imem_req_valid = armed_q;
            DELIVER: inst_valid     = 1'b1;
            HALT:    halted_out     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            armed_q  <= 1'b0;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            inst_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            unique case (1'b1)
                fetch_redirect:   pc_q <= redirect_target;
                drop_rsp:         pc_q <= resume_pc;
                deliver_redirect: pc_q <= redirect_target;
                rsp_take: begin
                    inst_q   <= imem_rsp_data;
                    pc_out_q <= pc_q;
                    pc_q     <= pc_q + ADDR_WIDTH'(PC_INCREMENT);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign inst_out  = inst_q;
    assign pc_out    = pc_out_q;
    assign opcode    = inst_q[OPCODE_MSB:OPCODE_LSB];
    assign func      = inst_q[FUNC_MSB:FUNC_LSB];

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fetch_count  <= '0;
            squash_count <= '0;
        end else begin
            if (hs && fetch_count != '1)
                fetch_count <= fetch_count + 32'd1;
            if ((drop_rsp || deliver_redirect) && squash_count != '1)
                squash_count <= squash_count + 32'd1;
        end
    end
`endif

    rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_b)
        imem_rsp_valid |-> state_q == WAIT
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a one-cycle
// instruction memory model and a decode-side handshake monitor.
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted;
    logic        halted_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          hs_cyc[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        mem_ready = 1'b1;
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] syscall_addr = 32'hDEAD_BEE0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == syscall_addr) return 32'h0000_000C;
        return 32'h8C00_0000 | {16'h0, a[15:0]};
    endfunction

    instruction_fetch_unit #(
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .func           (func),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .halted_out     (halted_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Decode flags SYSCALL combinationally from the presented word
    assign halted = inst_valid && opcode == OPCODE_RTYPE
                    && func == FUNC_SYSCALL;

    // Zero-wait memory: response in the cycle after acceptance
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pend  <= 1'b0;
            paddr <= '0;
        end else begin
            pend  <= imem_req_valid && mem_ready;
            paddr <= imem_addr;
        end
    end
    assign imem_req_ready = mem_ready;
    assign imem_rsp_valid = pend;
    assign imem_rsp_data  = word_at(paddr);

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (rst_b && inst_valid && inst_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_hs: got pc %h want none",
                         pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pc_out", pc_out, e.pc);
                check("inst_out", inst_out, e.inst);
                check("opcode", 32'(opcode), 32'(e.inst[31:26]));
                check("func", 32'(func), 32'(e.inst[5:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = word_at(a);
        sb.push_back(e);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            timeout(nm);
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 40 && !inst_valid; i++) tick();
        if (!inst_valid) timeout(nm);
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 40 && !imem_req_valid; i++) tick();
        if (!imem_req_valid) timeout(nm);
    endtask

    task automatic do_reset(input logic rdy);
        rst_b          = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_ready      = rdy;
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_halted_out", 32'(halted_out), 0);
        hs_cyc.delete();
        rst_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Sequential stream, one delivery every 3 cycles
        do_reset(1'b1);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        inst_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        push(32'h8);
        push(32'hC);
        wait_empty("seq");
        inst_ready = 1'b0;
        check("seq_hs_count", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                check("seq_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

        // Decode stall holds the word and blocks new requests
        push(32'h10);
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(inst_valid), 1);
            check("stall_pc", pc_out, 32'h10);
            check("stall_inst", inst_out, 32'h8C00_0010);
            check("stall_noreq", 32'(imem_req_valid), 0);
            tick();
        end
        inst_ready = 1'b1;
        wait_empty("stall_release");
        inst_ready = 1'b0;

        // Redirect coincident with acceptance of the 0x8 request
        do_reset(1'b1);
        inst_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        for (int i = 0; i < 40; i++) begin
            if (imem_req_valid && imem_addr == 32'h8) break;
            tick();
        end
        check("sq_at_8", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("sq_wait_noreq", 32'(imem_req_valid), 0);
        wait_req("sq_req");
        check("sq_req_addr", imem_addr, 32'h40);
        push(32'h40);
        wait_empty("sq_deliver");
        inst_ready = 1'b0;

        // Redirect while 0x10 sits in DELIVER
        do_reset(1'b1);
        inst_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        push(32'h8);
        push(32'hC);
        wait_empty("dr_prefix");
        inst_ready = 1'b0;
        wait_valid("dr_valid");
        check("dr_held_pc", pc_out, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("dr_valid_drop", 32'(inst_valid), 0);
        wait_req("dr_req");
        check("dr_req_addr", imem_addr, 32'h100);
        push(32'h100);
        inst_ready = 1'b1;
        wait_empty("dr_deliver");
        inst_ready = 1'b0;

        // SYSCALL handshake with a simultaneous redirect
        syscall_addr = 32'h8;
        do_reset(1'b1);
        inst_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        wait_empty("sc_prefix");
        inst_ready = 1'b0;
        push(32'h8);
        wait_valid("sc_valid");
        check("sc_halted_in", 32'(halted), 1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("sc_taken", sb.size(), 0);
        check("sc_halted_out", 32'(halted_out), 1);
        check("sc_inst_valid", 32'(inst_valid), 0);
        for (int i = 0; i < 6; i++) begin
            check("sc_noreq", 32'(imem_req_valid), 0);
            check("sc_stay", 32'(halted_out), 1);
            tick();
        end
        syscall_addr = 32'hDEAD_BEE0;

        // Stable address under backpressure, then reset in WAIT
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_req_valid", 32'(imem_req_valid), 1);
            check("bp_addr", imem_addr, 32'h0);
        end
        mem_ready = 1'b1;
        tick();
        check("wait_noreq", 32'(imem_req_valid), 0);
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_req", 32'(imem_req_valid), 0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_valid", 32'(inst_valid), 0);
        tick();
        rst_b = 1'b1;
        wait_req("post_rst_req");
        check("post_rst_addr", imem_addr, 32'h0);
        push(32'h0);
        inst_ready = 1'b1;
        wait_empty("post_rst_deliver");
        inst_ready = 1'b0;

        // FETCH-state redirect near the top of memory, then wrap
        do_reset(1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_req", 32'(imem_req_valid), 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        push(32'h0);
        mem_ready  = 1'b1;
        inst_ready = 1'b1;
        wait_empty("wrap_deliver");
        inst_ready = 1'b0;

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
